// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared UART types and baud constants.
// Revision : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    // 100 MHz system clock at 115200 baud.
    localparam int CLKS_PER_BIT_115200 = 868;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for a single asynchronous input.
// Revision : 1.0
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : uart_rx
// Brief    : 8N1 UART receiver, mid-bit sampling, glitch-start and framing-error handling.
// Revision : 1.0
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic       rx_ready,
    output logic [7:0] rdata,
    output logic       ferr,
    output logic       busy
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(HALF_BIT - 1);

    logic           rxd_s;
    uart_rx_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           rx_ready_q, rx_ready_d;
    logic           ferr_q, ferr_d;

    // Preset to 1 so the line reads idle straight out of reset.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rxd (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (rxd),
        .q_o    (rxd_s)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rdata_q    <= '0;
            rx_ready_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rdata_q    <= rdata_d;
            rx_ready_q <= rx_ready_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rdata_d    = rdata_q;
        rx_ready_d = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    // LSB arrives first, so shifting in at the MSB leaves bit 0 at the bottom.
                    shift_d   = {rxd_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        rdata_d    = shift_q;
                        rx_ready_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            BREAK: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_ready = rx_ready_q;
    assign ferr     = ferr_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != IDLE);

endmodule : uart_rx
`default_nettype wire
